// File: rtl/fixpoint_pkg.sv
// Shared fixed-point definitions: rounding-mode encodings, frame FSM states
// and the format-width helper used to size ports.
package fixpoint_pkg;

    localparam logic RND_TRUNC   = 1'b0;
    localparam logic RND_HALF_UP = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_e;

    function automatic int fmt_w(input int wi, input int wf);
        return wi + wf;
    endfunction

endpackage

// File: rtl/fixpoint_resize.sv
// Combinational fixed-point format converter: aligns the fraction (truncate or
// round-half-up), then fits the integer part by saturating or wrapping.
module fixpoint_resize
    import fixpoint_pkg::*;
#(
    parameter int WII = 14,
    parameter int WFI = 7,
    parameter int WIO = 9,
    parameter int WFO = 6
) (
    input  logic [WII+WFI-1:0] in,
    input  logic               rnd_mode,
    input  logic               sat_en,
    output logic [WIO+WFO-1:0] out,
    output logic               ovf
);
    localparam int WIN = WII + WFI;
    localparam int WE  = WII + WFO + 1;   // one spare bit absorbs the rounding carry
    localparam int WO  = WIO + WFO;

    logic signed [WE-1:0] aligned;

    generate
        if (WFO >= WFI) begin : g_pad
            assign aligned = WE'(signed'(in)) <<< (WFO - WFI);
        end else begin : g_rnd
            localparam int SH = WFI - WFO;
            localparam logic [WIN:0] HALF = (WIN+1)'(1) << (SH - 1);
            logic signed [WIN:0] ext;
            logic signed [WIN:0] sum;
            assign ext     = (WIN+1)'(signed'(in));
            assign sum     = ext + ((rnd_mode == RND_HALF_UP) ? HALF : '0);
            assign aligned = WE'(sum >>> SH);
        end

        if (WO >= WE) begin : g_ext
            assign out = WO'(aligned);
            assign ovf = 1'b0;
        end else begin : g_narrow
            logic [WE-WO:0] top;
            logic           fits;
            assign top  = aligned[WE-1:WO-1];
            assign fits = (&top) | ~(|top);
            always_comb begin
                out = aligned[WO-1:0];
                ovf = 1'b0;
                if (!fits) begin
                    ovf = 1'b1;
                    if (sat_en)
                        out = aligned[WE-1] ? {1'b1, {(WO-1){1'b0}}} : {1'b0, {(WO-1){1'b1}}};
                end
            end
        end
    endgenerate

endmodule

// File: rtl/fixpoint_mac.sv
// Framed fixed-point multiply-accumulate: multiply, accumulate per frame,
// then resize the frame total to the output format on a one-cycle strobe.
module fixpoint_mac
    import fixpoint_pkg::*;
#(
    parameter int WI1 = 5,
    parameter int WF1 = 4,
    parameter int WI2 = 7,
    parameter int WF2 = 3,
    parameter int WIA = 14,
    parameter int WFA = 7,
    parameter int WIO = 9,
    parameter int WFO = 6
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       in_valid,
    input  logic                       in_last,
    input  logic [fmt_w(WI1,WF1)-1:0]  in1,
    input  logic [fmt_w(WI2,WF2)-1:0]  in2,
    input  logic                       rnd_mode,
    input  logic                       sat_en,
    output logic [fmt_w(WIO,WFO)-1:0]  out,
    output logic                       out_valid,
    output logic                       OVF
);
    localparam int W1  = fmt_w(WI1, WF1);
    localparam int W2  = fmt_w(WI2, WF2);
    localparam int WP  = W1 + W2;
    localparam int WA  = fmt_w(WIA, WFA);
    localparam int WO  = fmt_w(WIO, WFO);
    localparam int PSH = WFA - WF1 - WF2;
    localparam logic signed [WA-1:0] ACC_MAX = {1'b0, {(WA-1){1'b1}}};
    localparam logic signed [WA-1:0] ACC_MIN = {1'b1, {(WA-1){1'b0}}};

    generate
        if (WFA < WF1 + WF2 || WIA < WI1 + WI2) begin : g_bad_fmt
            $error("fixpoint_mac: accumulator format cannot hold the full-precision product");
        end
    endgenerate

    // Stage 1: full-precision product plus term qualifiers
    logic s1_vld_d, s1_vld_q, s1_last_d, s1_last_q;
    logic s1_rnd_d, s1_rnd_q, s1_sat_d, s1_sat_q;
    logic signed [WP-1:0] s1_prod_d, s1_prod_q;

    always_comb begin
        s1_vld_d  = in_valid;
        s1_last_d = in_valid & in_last;
        s1_rnd_d  = rnd_mode;
        s1_sat_d  = sat_en;
        s1_prod_d = WP'(signed'(in1)) * WP'(signed'(in2));
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_rnd_q  <= 1'b0;
            s1_sat_q  <= 1'b0;
            s1_prod_q <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_last_q <= s1_last_d;
            s1_rnd_q  <= s1_rnd_d;
            s1_sat_q  <= s1_sat_d;
            s1_prod_q <= s1_prod_d;
        end
    end

    // Stage 2: frame FSM and accumulator
    state_e state_q, state_d;
    logic   acc_load, acc_add;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (s1_vld_q) state_d = s1_last_q ? ST_IDLE : ST_ACC;
    end

    always_comb begin
        acc_load = s1_vld_q && (state_q == ST_IDLE);
        acc_add  = s1_vld_q && (state_q == ST_ACC);
    end

    logic signed [WA-1:0] prod_ext, acc_d, acc_q;
    logic signed [WA:0]   sum;
    logic                 add_ovf, sticky_d, sticky_q;
    logic                 s2_done_d, s2_done_q, s2_rnd_d, s2_rnd_q, s2_sat_d, s2_sat_q;

    always_comb begin
        prod_ext  = WA'(s1_prod_q) <<< PSH;
        sum       = (WA+1)'(acc_q) + (WA+1)'(prod_ext);
        add_ovf   = sum[WA] ^ sum[WA-1];
        acc_d     = acc_q;
        sticky_d  = sticky_q;
        if (acc_load) begin
            acc_d    = prod_ext;
            sticky_d = 1'b0;
        end else if (acc_add) begin
            sticky_d = sticky_q | add_ovf;
            if (add_ovf && s1_sat_q) acc_d = sum[WA] ? ACC_MIN : ACC_MAX;
            else                     acc_d = sum[WA-1:0];
        end
        // Output modes travel with the last term; they only matter on s2_done_q
        s2_done_d = s1_last_q;
        s2_rnd_d  = s1_rnd_q;
        s2_sat_d  = s1_sat_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            acc_q     <= '0;
            sticky_q  <= 1'b0;
            s2_done_q <= 1'b0;
            s2_rnd_q  <= 1'b0;
            s2_sat_q  <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            sticky_q  <= sticky_d;
            s2_done_q <= s2_done_d;
            s2_rnd_q  <= s2_rnd_d;
            s2_sat_q  <= s2_sat_d;
        end
    end

    // Stage 3: resize the finished frame total
    logic [WO-1:0] rs_out, out_d, out_q;
    logic          rs_ovf, out_valid_d, out_valid_q, ovf_d, ovf_q;

    fixpoint_resize #(
        .WII(WIA), .WFI(WFA), .WIO(WIO), .WFO(WFO)
    ) u_resize (
        .in      (acc_q),
        .rnd_mode(s2_rnd_q),
        .sat_en  (s2_sat_q),
        .out     (rs_out),
        .ovf     (rs_ovf)
    );

    always_comb begin
        out_valid_d = s2_done_q;
        ovf_d       = s2_done_q & (sticky_q | rs_ovf);
        out_d       = s2_done_q ? rs_out : out_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign OVF       = ovf_q;

endmodule

// File: doc/fixpoint_mac.md
FIXPOINT_MAC -- requirements
Module: fixpoint_mac

Interface
REQ-001 The block SHALL take parameters WI1=5 and WF1=4, the integer and fraction bits of operand 1 (signed two's complement).
REQ-002 The block SHALL take parameters WI2=7 and WF2=3, the integer and fraction bits of operand 2.
REQ-003 The block SHALL take parameters WIA=14 and WFA=7, the accumulator integer and fraction bits; the constraints WFA>=WF1+WF2 and WIA>=WI1+WI2 SHALL be checked at elaboration.
REQ-004 The block SHALL take parameters WIO=9 and WFO=6, the output integer and fraction bits (any value >=1 / >=0).
REQ-005 The block SHALL have the ports below, in this order:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-low reset
- in_valid  in  1  term present this cycle
- in_last  in  1  final term of frame; qualified by in_valid
- in1  in  WI1+WF1  operand 1
- in2  in  WI2+WF2  operand 2
- rnd_mode  in  1  0 truncate toward -inf, 1 round-half-up; sampled with in_last
- sat_en  in  1  1 saturate, 0 wrap; sampled with in_last
- out  out  WIO+WFO  frame result
- out_valid  out  1  one-cycle result strobe
- OVF  out  1  overflow flag for the presented result

Function
REQ-006 Stage 1 SHALL register the full-precision product (WI1+WI2 integer, WF1+WF2 fraction) together with valid, last and the mode bits.
REQ-007 Stage 2 SHALL sign-extend the product and zero-pad its fraction to the accumulator format, then accumulate.
REQ-008 Frame FSM states SHALL be IDLE (no frame open) and ACC (frame open).
- IDLE + valid term: accumulator loads the product; go to ACC unless last.
- ACC + valid term: accumulator adds the product; on last, go to IDLE.
REQ-009 A term with in_valid=1 and in_last=1 while in IDLE SHALL form a single-term frame.
REQ-010 With in_valid=0 the pipeline SHALL advance bubbles, and accumulator and FSM SHALL hold; gaps inside a frame SHALL NOT change the result.
REQ-011 Back-to-back frames SHALL be supported with zero bubble: the term after a last SHALL reload the accumulator.
REQ-012 When an accumulation exceeds the accumulator range and sat_en=1, the accumulator SHALL clamp to max/min.
REQ-013 When an accumulation exceeds the accumulator range and sat_en=0, the accumulator SHALL wrap.
REQ-014 In either overflow case (REQ-012/013), a per-frame sticky flag SHALL be set.
REQ-015 Stage 3 SHALL resize the final accumulator value to the output format:
- fraction: truncate, or add 2^-(WFO+1) then truncate; zero-pad if WFO>WFA;
- integer: saturate or wrap per sat_en; sign-extend if WIO>WIA.
REQ-016 out_valid SHALL pulse exactly 3 cycles after the accepted last term (last at edge t -> out_valid high for cycle t+3).
REQ-017 OVF SHALL equal sticky-flag OR stage-3 overflow, SHALL be valid only with out_valid, and SHALL NOT leak into the next frame.
REQ-018 out SHALL hold its value between strobes.
REQ-019 The throughput SHALL be one term per cycle, with no backpressure.

Reset
REQ-020 On RST=0, asynchronously: out=0, out_valid=0, OVF=0, FSM=IDLE, accumulator, sticky flag and all pipeline valids cleared.
REQ-021 Reset mid-frame SHALL discard the frame; the first term after release SHALL start a new frame.

Structure
REQ-022 A shared package fixpoint_pkg SHALL hold the rounding-mode constants (RND_TRUNC, RND_HALF_UP), the FSM state typedef, and a format-width helper (WI+WF).
REQ-023 The stage-3 align/round/saturate logic SHALL be a sub-module fixpoint_resize (parameters WII, WFI, WIO, WFO; ports in, rnd_mode, sat_en, out, ovf), reusable by fixpoint_adder.

Verification (default parameters)
REQ-024 Single term in1=1.5, in2=2.25, last -> out=216 (3.375) 3 cycles later, OVF=0.
REQ-025 Four terms 1.0*1.0 with in_valid gaps between them -> out=256 (4.0), exactly one strobe.
REQ-026 Eight terms -16.0*-64.0 with sat_en=1 -> out=0x3FFF (max positive), OVF=1.
REQ-027 Repeat REQ-026 with sat_en=0 -> the wrapped value matching the model, OVF=1; next frame 1.0*1.0 -> out=64 with OVF=0.
REQ-028 in1=0.0625, in2=0.125 -> out=0 with rnd_mode=0, and out=1 with rnd_mode=1.
REQ-029 RST pulse after 2 of 4 terms -> no strobe, outputs zero; the following frame 2.0*1.0 -> out=128.
